// File: rtl/rf_pkg.sv
// Register-file constants and write-port types shared by the writeback path.
// Used by rf_wport_arbiter and the blocks that sit around the register file.
package rf_pkg;

  localparam int RF_AW   = 5;
  localparam int RF_DW   = 32;
  localparam int RF_NREG = 32;

  typedef logic [RF_AW-1:0] rf_waddr_t;
  typedef logic [RF_DW-1:0] rf_wdata_t;

  localparam rf_waddr_t RF_ZERO_REG = 5'd0;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first asserted req at or after ptr, wrapping modulo N.
// Produces a one-hot gnt (all zero when nothing requests) and the matching binary index.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx
);

  logic found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int k = 0; k < N; k++) begin
      automatic int idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        gnt[idx]   = 1'b1;
        gnt_idx    = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/rf_wport_arbiter.sv
// Round-robin arbiter sharing the single register-file write port between NREQ requesters.
// Optional per-requester accept counters and debug read port when RF_WPORT_STATS_EN is defined.
module rf_wport_arbiter
  import rf_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int AW   = RF_AW,
  parameter int DW   = RF_DW
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic                 rf_we,
  output logic [AW-1:0]        rf_wa,
  output logic [DW-1:0]        rf_wd,
  output logic                 pend_valid,
  output logic [AW-1:0]        pend_addr
`ifdef RF_WPORT_STATS_EN
  ,
  input  logic [1:0]           dbg_sel,
  output logic [15:0]          dbg_cnt
`endif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   ptr;
  logic [PW-1:0]   ptr_nxt;
  logic [PW-1:0]   gnt_idx;
  logic [NREQ-1:0] gnt;
  logic            accept;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;

  rr_arbiter #(
    .N  (NREQ),
    .PW (PW)
  ) u_rr (
    .req     (req_valid),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Ready is forced low while reset is held so nothing is accepted into a stage being cleared.
  assign req_ready = rstn ? gnt : '0;
  assign accept    = |(req_valid & req_ready);
  assign sel_addr  = req_addr[gnt_idx*AW +: AW];
  assign sel_data  = req_data[gnt_idx*DW +: DW];
  assign ptr_nxt   = (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rf_we <= 1'b0;
      rf_wa <= '0;
      rf_wd <= '0;
      ptr   <= '0;
    end else if (accept) begin
      // x0 writes still load the address/data flops; only the enable is suppressed.
      rf_we <= (sel_addr != AW'(RF_ZERO_REG));
      rf_wa <= sel_addr;
      rf_wd <= sel_data;
      ptr   <= ptr_nxt;
    end else begin
      rf_we <= 1'b0;
    end
  end

  assign pend_valid = rf_we;
  assign pend_addr  = rf_wa;

`ifdef RF_WPORT_STATS_EN
  logic [15:0] acc_cnt [NREQ];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NREQ; i++) acc_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i] && (acc_cnt[i] != 16'hFFFF))
          acc_cnt[i] <= acc_cnt[i] + 16'd1;
      end
    end
  end

  always_comb begin
    dbg_cnt = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (dbg_sel == 2'(i)) dbg_cnt = acc_cnt[i];
    end
  end
`endif

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Self-checking bench for rf_wport_arbiter: directed scenarios plus a randomized run
// against a behavioural round-robin / register-file model.
module tb_rf_wport_arbiter;
  import rf_pkg::*;

  localparam int NREQ = 2;
  localparam int AW   = RF_AW;
  localparam int DW   = RF_DW;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*DW-1:0]   req_data;
  logic                 rf_we;
  logic [AW-1:0]        rf_wa;
  logic [DW-1:0]        rf_wd;
  logic                 pend_valid;
  logic [AW-1:0]        pend_addr;
`ifdef RF_WPORT_STATS_EN
  logic [1:0]           dbg_sel;
  logic [15:0]          dbg_cnt;
`endif

  logic [NREQ-1:0] v;
  logic [AW-1:0]   a [NREQ];
  logic [DW-1:0]   d [NREQ];

  always_comb begin
    req_valid = v;
    req_addr  = '0;
    req_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i*AW +: AW] = a[i];
      req_data[i*DW +: DW] = d[i];
    end
  end

  rf_wport_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .rf_we      (rf_we),
    .rf_wa      (rf_wa),
    .rf_wd      (rf_wd),
    .pend_valid (pend_valid),
    .pend_addr  (pend_addr)
`ifdef RF_WPORT_STATS_EN
    ,
    .dbg_sel    (dbg_sel),
    .dbg_cnt    (dbg_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk;
  int n_pass;

  // Reference model state
  int            mptr;
  int            last_acc;
  logic          exp_we;
  logic [AW-1:0] exp_wa;
  logic [DW-1:0] exp_wd;
  logic [DW-1:0] m_rf [32];

  // Register file built from what the DUT actually drives onto the write port
  logic          rf_live;
  logic [DW-1:0] d_rf [32];

  always @(posedge clk) begin
    if (!rf_live) begin
      for (int i = 0; i < 32; i++) d_rf[i] <= '0;
    end else if (rstn && rf_we) begin
      d_rf[rf_wa] <= rf_wd;
    end
  end

  function automatic int model_grant();
    for (int k = 0; k < NREQ; k++) begin
      automatic int idx = (mptr + k) % NREQ;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] exp_ready();
    logic [NREQ-1:0] r;
    int g;
    r = '0;
    g = model_grant();
    if (rstn && g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  function automatic int dut_grant();
    for (int i = 0; i < NREQ; i++) if (req_ready[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    mptr     = 0;
    last_acc = -1;
    exp_we   = 1'b0;
    exp_wa   = '0;
    exp_wd   = '0;
  endtask

  // Advance one clock and update the model; leaves time at posedge+1.
  task automatic tick();
    int g;
    g = rstn ? model_grant() : -1;
    @(posedge clk);
    if (rstn) begin
      if (exp_we) m_rf[exp_wa] = exp_wd;
      if (g >= 0) begin
        exp_we = (a[g] != '0);
        exp_wa = a[g];
        exp_wd = d[g];
        mptr   = (g + 1) % NREQ;
      end else begin
        exp_we = 1'b0;
      end
    end
    last_acc = g;
    #1;
  endtask

  task automatic renew(input int i);
    a[i] = AW'($urandom_range(1, 31));
    d[i] = $urandom;
  endtask

  task automatic test_reset();
    n_chk++; if (rf_we !== 1'b0) $display("FAIL reset_we: got %b exp 0", rf_we); else n_pass++;
    n_chk++; if (rf_wa !== '0) $display("FAIL reset_wa: got %0d exp 0", rf_wa); else n_pass++;
    n_chk++; if (rf_wd !== '0) $display("FAIL reset_wd: got %h exp 0", rf_wd); else n_pass++;
    v = '1; a[0] = 5'd7; a[1] = 5'd9; d[0] = $urandom; d[1] = $urandom;
    #1;
    n_chk++; if (req_ready !== 2'b00) $display("FAIL reset_ready: got %b exp 00", req_ready); else n_pass++;
    @(posedge clk); #1;
    rstn = 1'b1;
    #1;
    n_chk++; if (req_ready !== 2'b01) $display("FAIL first_grant: got %b exp 01", req_ready); else n_pass++;
    tick();
    n_chk++; if (rf_we !== 1'b1 || rf_wa !== 5'd7 || rf_wd !== d[0])
      $display("FAIL first_write: got we=%b wa=%0d wd=%h exp we=1 wa=7 wd=%h", rf_we, rf_wa, rf_wd, d[0]);
    else n_pass++;
    repeat (3) begin
      if (last_acc >= 0) renew(last_acc);
      #1;
      n_chk++; if (req_ready !== exp_ready()) $display("FAIL pre_rst_ready: got %b exp %b", req_ready, exp_ready()); else n_pass++;
      tick();
      n_chk++; if (rf_we !== exp_we || rf_wa !== exp_wa) $display("FAIL pre_rst_out: got we=%b wa=%0d exp we=%b wa=%0d", rf_we, rf_wa, exp_we, exp_wa); else n_pass++;
    end
    rstn = 1'b0;
    #1;
    n_chk++; if (rf_we !== 1'b0 || pend_valid !== 1'b0) $display("FAIL midrst_we: got we=%b pv=%b exp 0", rf_we, pend_valid); else n_pass++;
    n_chk++; if (req_ready !== 2'b00) $display("FAIL midrst_ready: got %b exp 00", req_ready); else n_pass++;
    model_reset();
    tick();
    n_chk++; if (rf_we !== 1'b0) $display("FAIL midrst_hold_we: got %b exp 0", rf_we); else n_pass++;
    rstn = 1'b1;
    #1;
    n_chk++; if (req_ready !== 2'b01) $display("FAIL postrst_grant: got %b exp 01", req_ready); else n_pass++;
    tick();
    n_chk++; if (rf_we !== 1'b1 || rf_wa !== a[0] || rf_wd !== d[0])
      $display("FAIL postrst_write: got we=%b wa=%0d wd=%h exp we=1 wa=%0d wd=%h", rf_we, rf_wa, rf_wd, a[0], d[0]);
    else n_pass++;
    v = '0;
    tick();
  endtask

  task automatic test_single();
    v = 2'b01; a[0] = 5'd5; d[0] = 32'hDEADBEEF;
    #1;
    n_chk++; if (req_ready !== 2'b01) $display("FAIL single_ready: got %b exp 01", req_ready); else n_pass++;
    tick();
    n_chk++; if (rf_we !== 1'b1 || rf_wa !== 5'd5 || rf_wd !== 32'hDEADBEEF)
      $display("FAIL single_write: got we=%b wa=%0d wd=%h exp we=1 wa=5 wd=deadbeef", rf_we, rf_wa, rf_wd);
    else n_pass++;
    v = '0;
    #1;
    n_chk++; if (req_ready !== 2'b00) $display("FAIL single_idle_ready: got %b exp 00", req_ready); else n_pass++;
    tick();
    n_chk++; if (rf_we !== 1'b0 || rf_wa !== 5'd5 || rf_wd !== 32'hDEADBEEF)
      $display("FAIL single_idle: got we=%b wa=%0d wd=%h exp we=0 wa=5 wd=deadbeef", rf_we, rf_wa, rf_wd);
    else n_pass++;
  endtask

  task automatic test_contention();
    int waitc [NREQ];
    int prev;
    int g;
    prev = -1;
    for (int i = 0; i < NREQ; i++) begin waitc[i] = 0; renew(i); end
    v = '1;
    repeat (20) begin
      #1;
      n_chk++; if (req_ready !== exp_ready()) $display("FAIL cont_ready: got %b exp %b", req_ready, exp_ready()); else n_pass++;
      g = dut_grant();
      if (prev >= 0) begin
        n_chk++; if (g != 1 - prev) $display("FAIL cont_alternate: got %0d exp %0d", g, 1 - prev); else n_pass++;
      end
      prev = g;
      tick();
      n_chk++; if (rf_we !== 1'b1 || rf_wa !== exp_wa || rf_wd !== exp_wd)
        $display("FAIL cont_write: got we=%b wa=%0d wd=%h exp we=1 wa=%0d wd=%h", rf_we, rf_wa, rf_wd, exp_wa, exp_wd);
      else n_pass++;
      for (int i = 0; i < NREQ; i++) begin
        waitc[i] = (i == g) ? 0 : waitc[i] + 1;
        n_chk++; if (waitc[i] >= 2) $display("FAIL cont_starve: req %0d waited %0d exp <2", i, waitc[i]); else n_pass++;
      end
      if (g >= 0) renew(g);
    end
    v = '0;
    tick();
  endtask

  task automatic test_x0();
    v = 2'b10; a[1] = '0; d[1] = 32'h1234;
    #1;
    n_chk++; if (req_ready !== 2'b10) $display("FAIL x0_ready: got %b exp 10", req_ready); else n_pass++;
    tick();
    v = '0;
    n_chk++; if (rf_we !== 1'b0 || pend_valid !== 1'b0) $display("FAIL x0_we: got we=%b pv=%b exp 0", rf_we, pend_valid); else n_pass++;
    n_chk++; if (rf_wa !== '0 || rf_wd !== 32'h1234) $display("FAIL x0_load: got wa=%0d wd=%h exp wa=0 wd=1234", rf_wa, rf_wd); else n_pass++;
    tick();
    tick();
    n_chk++; if (d_rf[0] !== '0) $display("FAIL x0_rf: got x0=%h exp 0", d_rf[0]); else n_pass++;
  endtask

  task automatic test_back_to_back();
    v = 2'b01; a[0] = 5'd3; d[0] = 32'd1;
    #1;
    n_chk++; if (req_ready !== 2'b01) $display("FAIL b2b_ready0: got %b exp 01", req_ready); else n_pass++;
    tick();
    v = 2'b10; a[1] = 5'd3; d[1] = 32'd2;
    n_chk++; if (rf_we !== 1'b1 || pend_addr !== 5'd3 || rf_wd !== 32'd1)
      $display("FAIL b2b_first: got we=%b pa=%0d wd=%h exp we=1 pa=3 wd=1", rf_we, pend_addr, rf_wd);
    else n_pass++;
    #1;
    n_chk++; if (req_ready !== 2'b10) $display("FAIL b2b_ready1: got %b exp 10", req_ready); else n_pass++;
    tick();
    v = '0;
    n_chk++; if (pend_valid !== 1'b1 || pend_addr !== 5'd3 || rf_wd !== 32'd2)
      $display("FAIL b2b_second: got pv=%b pa=%0d wd=%h exp pv=1 pa=3 wd=2", pend_valid, pend_addr, rf_wd);
    else n_pass++;
    tick();
    tick();
    n_chk++; if (d_rf[3] !== 32'd2) $display("FAIL b2b_x3: got %h exp 2", d_rf[3]); else n_pass++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!v[i] || last_acc == i) begin
          if ($urandom_range(0, 9) < 6) begin
            v[i] = 1'b1;
            a[i] = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(1, 31));
            d[i] = $urandom;
          end else begin
            v[i] = 1'b0;
          end
        end
      end
      #1;
      n_chk++; if (req_ready !== exp_ready()) $display("FAIL rnd_ready c=%0d: got %b exp %b", c, req_ready, exp_ready()); else n_pass++;
      tick();
      n_chk++; if (rf_we !== exp_we || pend_valid !== exp_we) $display("FAIL rnd_we c=%0d: got we=%b pv=%b exp %b", c, rf_we, pend_valid, exp_we); else n_pass++;
      n_chk++; if (rf_wa !== exp_wa || pend_addr !== exp_wa || rf_wd !== exp_wd)
        $display("FAIL rnd_data c=%0d: got wa=%0d pa=%0d wd=%h exp wa=%0d wd=%h", c, rf_wa, pend_addr, rf_wd, exp_wa, exp_wd);
      else n_pass++;
      n_chk++; if (rf_we === 1'b1 && rf_wa === '0) $display("FAIL rnd_x0_we c=%0d: got we=1 wa=0 exp no x0 write", c); else n_pass++;
    end
    v = '0;
    tick();
    tick();
    for (int r = 0; r < 32; r++) begin
      n_chk++; if (d_rf[r] !== m_rf[r]) $display("FAIL rnd_rf x%0d: got %h exp %h", r, d_rf[r], m_rf[r]); else n_pass++;
    end
  endtask

`ifdef RF_WPORT_STATS_EN
  task automatic test_stats();
    v = '0;
    rstn = 1'b0;
    model_reset();
    #2;
    rstn = 1'b1;
    v = 2'b01; a[0] = 5'd1; d[0] = 32'd7;
    repeat (70000) @(posedge clk);
    #1;
    v = '0;
    dbg_sel = 2'd0;
    #1;
    n_chk++; if (dbg_cnt !== 16'hFFFF) $display("FAIL stats_sat: got %h exp ffff", dbg_cnt); else n_pass++;
    dbg_sel = 2'd1;
    #1;
    n_chk++; if (dbg_cnt !== 16'h0000) $display("FAIL stats_idle: got %h exp 0", dbg_cnt); else n_pass++;
    dbg_sel = 2'd3;
    #1;
    n_chk++; if (dbg_cnt !== 16'h0000) $display("FAIL stats_oob: got %h exp 0", dbg_cnt); else n_pass++;
  endtask
`endif

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk   = 0;
    n_pass  = 0;
    rstn    = 1'b0;
    rf_live = 1'b0;
    v       = '0;
    for (int i = 0; i < NREQ; i++) begin a[i] = '0; d[i] = '0; end
    for (int r = 0; r < 32; r++) m_rf[r] = '0;
`ifdef RF_WPORT_STATS_EN
    dbg_sel = 2'd0;
`endif
    model_reset();
    @(posedge clk); #1;
    rf_live = 1'b1;
    test_reset();
    test_single();
    test_contention();
    test_x0();
    test_back_to_back();
    test_random();
`ifdef RF_WPORT_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
